mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory bus between the fetch stage (instruction reads) and the
//  mem_branch stage (data reads/writes), with one transaction in flight at a time.
//  Data requests have priority; a starvation counter guarantees fetch progress.
//  Drops the fetch response after a pipe_flush so that stale instructions never reach decode.
//  Sits between fetch/mem_branch and the memory; its busy/gnt outputs feed the stall logic.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width; strobe width is DATA_W/8
//  STARVE_MAX  4   consecutive lost contests before fetch is forced to win (1..15)
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         synchronous, active-high reset
//  pipe_flush  in   1         pipeline flush from fetch; kills the current/pending fetch
//  if_req      in   1         fetch request; hold with if_addr stable until if_gnt
//  if_addr     in   ADDR_W    fetch address (read only)
//  if_gnt      out  1         request accepted this cycle (combinational, IDLE only)
//  if_rvalid   out  1         registered one-cycle pulse: if_rdata valid
//  if_rdata    out  DATA_W    instruction word
//  d_req       in   1         data request; hold fields stable until d_gnt
//  d_we        in   1         1 = write, 0 = read
//  d_addr      in   ADDR_W    data address
//  d_wstrb     in   DATA_W/8  byte strobes (writes)
//  d_wdata     in   DATA_W    write data
//  d_gnt       out  1         request accepted this cycle (combinational, IDLE only)
//  d_rvalid    out  1         registered pulse: read data / write ack
//  d_rdata     out  DATA_W    read data (undefined for writes)
//  mem_req     out  1         registered; held until mem_gnt
//  mem_we, mem_addr, mem_wstrb, mem_wdata  out  registered copies of the granted request
//  mem_gnt     in   1         memory accepted mem_req
//  mem_rvalid  in   1         response pulse (reads and writes), any latency >= 0 after mem_gnt
//  mem_rdata   in   DATA_W    response data
//  busy        out  1         state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req, if_rvalid, d_rvalid, busy = 0; starve_cnt = 0; drop = 0;
//    owner = IF; rdata regs = 0. Reset mid-transaction abandons it. A late mem_rvalid is ignored.
//  - States: IDLE -> ISSUE -> WAIT -> IDLE.
//    IDLE: pick a winner. d_req wins, unless if_req && starve_cnt == STARVE_MAX, in which case fetch wins.
//      If_gnt is suppressed while pipe_flush=1. Assert the winner's gnt, latch its fields into the mem_* regs,
//      set owner, go to ISSUE. mem_req=1 from the next cycle (grant at N -> mem_req at N+1).
//    ISSUE: hold mem_req and the fields until mem_gnt.
//      mem_gnt && !mem_rvalid -> WAIT, mem_req=0.
//      mem_gnt && mem_rvalid -> complete directly to IDLE.
//    WAIT: on mem_rvalid, register mem_rdata into the owner's rdata and pulse its rvalid the
//      next cycle, then return to IDLE. A new grant is legal in that same cycle (1-cycle turnaround).
//  - starve_cnt: +1 in each IDLE cycle with if_req && d_req where data wins (saturating at STARVE_MAX).
//    It clears whenever fetch is granted.
//  - Flush: pipe_flush while owner=IF in ISSUE/WAIT (or in the completion cycle) sets drop.
//    The bus transaction still finishes, but if_rvalid is suppressed. drop clears on return to IDLE.
//    Data transactions are never dropped.
//  - mem_rvalid in IDLE, or in ISSUE without mem_gnt, is ignored.
//  - The rvalid outputs are never both high. Each gnt yields exactly one rvalid, except dropped fetches.
// STRUCTURE
//  - bus.vh: state encodings (ST_IDLE/ST_ISSUE/ST_WAIT), owner codes (OWN_IF/OWN_D),
//    STARVE_W width define; included alongside control.vh.
//  - Sub-module arb_pick (combinational winner select + starve_cnt register). FSM and datapath
//    regs stay in mem_arbiter.
// TESTING
//  1. Fetch only, mem latency 2: if_req addr 0x100 -> if_gnt at N, mem_req N+1..gnt,
//     if_rvalid 1 cycle after mem_rvalid with if_rdata == mem_rdata.
//  2. Simultaneous if_req/d_req, STARVE_MAX=4, d_req held high: data wins 4 contests,
//     fetch wins the 5th, starve_cnt back to 0.
//  3. Data write 0xDEADBEEF strb 4'b0011 @0x2000: mem_* fields match exactly, d_rvalid pulses once,
//     if_rvalid stays 0.
//  4. pipe_flush during WAIT of fetch @0x40: mem transaction completes, if_rvalid never asserts,
//     next if_req granted normally.
//  5. mem_gnt and mem_rvalid in the same cycle (zero latency): FSM skips WAIT,
//     response delivered next cycle.
//  6. rst asserted in WAIT, then stray mem_rvalid: all outputs 0, state IDLE,
//     no rvalid to either requester.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg                                                            |
// | Shared state, owner and counter-width definitions for the bus arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_pick                                                                   |
// | Winner select between fetch and data plus the fetch starvation counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
)
(
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_pipe_flush,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_gnt,
  output logic o_d_gnt
);

  localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_if_win;
  logic                w_d_win;

  // Data normally wins; fetch wins once it has lost STARVE_MAX contests in a row.
  always_comb begin
    w_if_win = i_if_req && !i_pipe_flush && (!i_d_req || (r_starve_cnt == c_starve_max));
    w_d_win  = i_d_req && !w_if_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_idle) begin
      if (w_if_win) begin
        r_starve_cnt <= '0;
      end else if (w_d_win && i_if_req && (r_starve_cnt != c_starve_max)) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end
    end
  end

  assign o_if_gnt = i_idle && w_if_win;
  assign o_d_gnt  = i_idle && w_d_win;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Single-outstanding arbiter sharing one memory bus between fetch and data.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic                r_drop;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W/8-1:0] r_mem_wstrb;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_idle;
  logic                w_if_gnt;
  logic                w_d_gnt;
  logic                w_complete;
  logic                w_flush_hit;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_flush_hit = pipe_flush && (r_owner == OWN_IF) && !w_idle;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_pick (
    .clk          (clk),
    .rst          (rst),
    .i_idle       (w_idle),
    .i_pipe_flush (pipe_flush),
    .i_if_req     (if_req),
    .i_d_req      (d_req),
    .o_if_gnt     (w_if_gnt),
    .o_d_gnt      (w_d_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response accepted with the memory grant skips WAIT entirely.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_if_gnt || w_d_gnt) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
          w_complete  = mem_rvalid;
          w_state_nxt = mem_rvalid ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_IF;
      r_drop      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;

      if (w_if_gnt) begin
        r_owner     <= OWN_IF;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wstrb <= '0;
        r_mem_wdata <= '0;
      end else if (w_d_gnt) begin
        r_owner     <= OWN_D;
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wstrb <= d_wstrb;
        r_mem_wdata <= d_wdata;
      end else if ((r_state == ST_ISSUE) && mem_gnt) begin
        r_mem_req   <= 1'b0;
      end

      // A flush in the completion cycle itself must still hide the fetch response.
      if (w_complete) begin
        r_drop <= 1'b0;
        if (r_owner == OWN_IF) begin
          r_if_rdata  <= mem_rdata;
          r_if_rvalid <= !(r_drop || w_flush_hit);
        end else begin
          r_d_rdata   <= mem_rdata;
          r_d_rvalid  <= 1'b1;
        end
      end else if (w_flush_hit) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign busy      = !w_idle;

endmodule
`default_nettype wire
